pwm_output_gen: RTL

PWM_OUTPUT_GEN -- requirements
Module: pwm_output_gen

---
 rtl/pwm_output_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pwm_output_gen.sv
// pwm_output_gen: servo-style PWM generator for an ESC with arming, link-loss
// failsafe and frame-synchronous width updates.
// Optional feature macro: FAILSAFE_SILENT_EN (silence the output in FAILSAFE).
module pwm_output_gen #(
   parameter int PERIOD_CYCLES  = 320000,
   parameter int MIN_CYCLES     = 16000,
   parameter int ARM_FRAMES     = 10,
   parameter int TIMEOUT_CYCLES = 1600000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_strobe,
   input  logic [10:0] set_speed,
   input  logic        is_special_command,
   input  logic [5:0]  special_command,
   input  logic        crc_valid,
   output logic        pwm_out,
   output logic        armed,
   output logic        failsafe,
   output logic [1:0]  state,
   output logic [14:0] active_width
);
   localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(ARM_FRAMES + 1);

   localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
   localparam logic [TW-1:0] TMO_FULL    = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW-1:0] ARM_TARGET  = AW'(ARM_FRAMES);
   localparam logic [14:0]   MIN_W       = 15'(MIN_CYCLES);

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMING   = 2'd1,
      ARMED    = 2'd2,
      FAILSAFE = 2'd3
   } state_t;

   state_t        curState, nextState;
   logic [AW-1:0] armCnt, armCntNext, armInc;
   logic [TW-1:0] timeoutCnt, timeoutNext;
   logic [14:0]   pendingTarget, pendingNext;
   logic [14:0]   activeWidth, frameWidth, speedWidth;
   logic [10:0]   speedClamped;
   logic [PW-1:0] periodCnt;
   logic          goodFrame, zeroFrame, throttleFrame, expire, periodStart;

   assign goodFrame     = frame_strobe && crc_valid;
   assign zeroFrame     = goodFrame && (is_special_command ? (special_command == 6'd0)
                                                           : (set_speed == 11'd0));
   assign throttleFrame = goodFrame && !is_special_command && (set_speed != 11'd0);
   // A good frame in the expiry cycle wins, so expiry is gated by !goodFrame.
   assign expire        = !goodFrame && (timeoutCnt >= TMO_LAST);
   assign armInc        = armCnt + AW'(1);
   assign periodStart   = (periodCnt == '0);

   // Throttle-to-width mapping with clamp at 1999.
   always_comb begin
      speedClamped = (set_speed > 11'd1999) ? 11'd1999 : set_speed;
      speedWidth   = MIN_W + {1'b0, speedClamped, 3'b000};
   end

   // Next-state, arm counter, timeout counter and pending target.
   always_comb begin
      nextState   = curState;
      armCntNext  = armCnt;
      pendingNext = pendingTarget;
      timeoutNext = goodFrame ? '0 :
                    (timeoutCnt == TMO_FULL) ? timeoutCnt : timeoutCnt + TW'(1);
      case (curState)
         DISARMED: begin
            pendingNext = MIN_W;
            if (zeroFrame) begin
               armCntNext = AW'(1);
               nextState  = (ARM_FRAMES <= 1) ? ARMED : ARMING;
            end
         end
         ARMING: begin
            pendingNext = MIN_W;
            if (zeroFrame) begin
               armCntNext = armInc;
               if (armInc >= ARM_TARGET) nextState = ARMED;
            end else if (goodFrame) begin
               armCntNext = '0;
               nextState  = DISARMED;
            end
         end
         ARMED: begin
            if (throttleFrame)  pendingNext = speedWidth;
            else if (zeroFrame) pendingNext = MIN_W;
         end
         FAILSAFE: begin
            if (zeroFrame) begin
               armCntNext = AW'(1);
               nextState  = (ARM_FRAMES <= 1) ? ARMED : ARMING;
            end
         end
         default: nextState = DISARMED;
      endcase
      if (expire && curState != FAILSAFE) begin
         nextState   = FAILSAFE;
         armCntNext  = '0;
         pendingNext = MIN_W;
      end
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         curState      <= DISARMED;
         armCnt        <= '0;
         timeoutCnt    <= '0;
         pendingTarget <= MIN_W;
      end else begin
         curState      <= nextState;
         armCnt        <= armCntNext;
         timeoutCnt    <= timeoutNext;
         pendingTarget <= pendingNext;
      end
   end

   // At count 0 the pulse uses the pending value being latched this edge.
   assign frameWidth = periodStart ? pendingTarget : activeWidth;

`ifdef FAILSAFE_SILENT_EN
   logic silentFrame, silentNow;
   assign silentNow = periodStart ? (curState == FAILSAFE) : silentFrame;

   // Period counter, frame-latched width and silenced PWM output.
   always_ff @(posedge clk) begin
      if (reset) begin
         periodCnt   <= '0;
         activeWidth <= MIN_W;
         silentFrame <= 1'b0;
         pwm_out     <= 1'b0;
      end else begin
         periodCnt <= (periodCnt == PERIOD_LAST) ? '0 : periodCnt + PW'(1);
         if (periodStart) begin
            activeWidth <= pendingTarget;
            silentFrame <= (curState == FAILSAFE);
         end
         pwm_out <= (curState != FAILSAFE) && !silentNow &&
                    (32'(periodCnt) < 32'(frameWidth));
      end
   end

   assign active_width = ((curState == FAILSAFE) || silentFrame) ? 15'd0 : activeWidth;
`else
   // Period counter, frame-latched width and PWM output.
   always_ff @(posedge clk) begin
      if (reset) begin
         periodCnt   <= '0;
         activeWidth <= MIN_W;
         pwm_out     <= 1'b0;
      end else begin
         periodCnt <= (periodCnt == PERIOD_LAST) ? '0 : periodCnt + PW'(1);
         if (periodStart) activeWidth <= pendingTarget;
         pwm_out <= (32'(periodCnt) < 32'(frameWidth));
      end
   end

   assign active_width = activeWidth;
`endif

   assign state    = curState;
   assign armed    = (curState == ARMED);
   assign failsafe = (curState == FAILSAFE);
endmodule
